exc_flush_ctrl: RTL and testbench
=================================

Name: exc_flush_ctrl

Overview:
- Sequences pipeline recovery on commit-time events: synchronous exceptions from WB, ERTN, and pending interrupts.
- Arbitrates simultaneous events and pulses the CSR file to latch exception state.
- Flushes IF/ID/EXE/MEM for a programmable number of cycles, then holds a redirect PC toward IF until it is accepted.
- Sits beside WB and the CSR file; is the only source of pipeline flush and redirect.

Parameters:
FLUSH_CYCLES, 1, cycles flush_bus stays asserted after an event (1..15)
CNT_W, 4, width of the flush counter

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
wb_valid  in  1  a valid instruction is in WB this cycle
wb_ex  in  1  WB instruction raised a synchronous exception
wb_ecode  in  6  exception code from WB
wb_esubcode  in  9  exception subcode from WB
wb_pc  in  32  PC of the WB instruction
wb_ertn  in  1  WB instruction is ERTN
has_int  in  1  CSR reports an enabled pending interrupt (already IE-gated)
csr_eentry  in  32  exception entry address
csr_era  in  32  exception return address
ex_commit  out  1  one-cycle pulse; CSR saves ERA/ESTAT/PRMD
ex_ecode  out  6  ecode qualified by ex_commit
ex_esubcode  out  9  esubcode qualified by ex_commit
ex_pc  out  32  PC written to ERA, qualified by ex_commit
ertn_commit  out  1  one-cycle pulse; CSR restores CRMD from PRMD
commit_inhibit  out  1  WB must suppress rf_we and csr_we this cycle
flush_bus  out  4  {if,id,exe,mem} flush
redirect_valid  out  1  redirect_pc valid toward IF
redirect_pc  out  32  new fetch PC
redirect_ready  in  1  IF accepts redirect

Behaviour:
- Reset: state IDLE, counter 0. All outputs 0: flush_bus=4'b0, redirect_pc=32'b0.
- States: IDLE, FLUSH, REDIRECT.
- Event detection happens in IDLE only, when wb_valid=1. Priority:
  1. int (has_int)
  2. exc (wb_ex)
  3. ertn (wb_ertn)
- Event in IDLE, cycle T. Outputs are combinational in T:
  - int: ex_commit=1, ex_ecode=6'h00, ex_esubcode=0.
  - exc: ex_commit=1, ex_ecode/ex_esubcode = wb_ecode/wb_esubcode.
  - ertn: ertn_commit=1; ex_commit=0.
  - All events: commit_inhibit=1, ex_pc=wb_pc.
  - wb_ertn together with int/exc: ertn_commit stays 0.
- Target capture, at the T edge:
  - int/exc: target <= csr_eentry.
  - ertn: target <= csr_era, sampled in T, before the CSR update is visible.
  - State -> FLUSH, counter <= FLUSH_CYCLES-1.
- FLUSH:
  - flush_bus=4'b1111, commit_inhibit=1.
  - Counter decrements each cycle; at 0, state -> REDIRECT.
  - Exactly FLUSH_CYCLES cycles of flush, covering T+1 .. T+FLUSH_CYCLES.
- REDIRECT:
  - redirect_valid=1, redirect_pc=target, flush_bus=4'b1111, commit_inhibit=1.
  - Hold until redirect_ready=1. On the handshake cycle, state -> IDLE.
  - redirect_pc stays stable while waiting; redirect_valid never drops without a handshake.
- Outside IDLE, all event inputs are ignored; ex_commit=ertn_commit=0. Further exceptions cannot nest.
- Without wb_valid, wb_ex/wb_ertn/has_int are ignored. Interrupts are taken only at an instruction boundary.
- redirect_ready with redirect_valid=0: no effect.
- Reset in any state: IDLE next edge, outputs 0, captured target discarded.
- Minimum event-to-fetch latency: FLUSH_CYCLES+1 cycles, with redirect_ready tied 1.

Decomposition:
- Shared defines header: ECODE_INT (6'h00), the existing ECODE_SYS etc., state encodings (IDLE=2'd0, FLUSH=2'd1, REDIRECT=2'd2).
- Single module. The priority encoder may be a small sub-module, exc_prio_enc (inputs: int/exc/ertn; outputs: one-hot sel, ecode/esubcode mux).

Test Plan:
- Syscall: wb_valid=1, wb_ex=1, ecode=6'h0B, wb_pc=0x1C000100, eentry=0x1C008000, ready=1.
  - Expect ex_commit pulse at T with ex_pc=0x1C000100, ecode 0x0B.
  - flush_bus=F at T+1; redirect_valid with pc 0x1C008000 at T+2; IDLE at T+3.
- ERTN: wb_ertn=1, era=0x1C000104.
  - Expect ertn_commit at T, ex_commit=0, redirect_pc=0x1C000104.
- Priority: has_int=1 and wb_ex=1 (ecode 0x0B) in the same cycle.
  - Expect ex_ecode=0x00; exactly one ex_commit.
  - has_int with wb_valid=0 -> no action until the next valid cycle.
- Backpressure: redirect_ready=0 for 5 cycles.
  - redirect_valid and pc are stable; a second wb_ex during the wait is ignored; accepted on the 6th cycle.
- FLUSH_CYCLES=3: flush_bus=F for 3 cycles before redirect_valid; commit_inhibit high throughout.
- Reset mid-operation: resetn=0 in REDIRECT.
  - All outputs 0 next cycle; a new event after release behaves normally.

Source files
------------

// File: rtl/exc_flush_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// exc_flush_ctrl_pkg
// Shared definitions for the commit-time exception / flush controller:
//   - exception codes used at commit (ECODE_INT is what an interrupt reports)
//   - FSM state encoding (also visible on the controller's debug state port)
//   - bit positions of the one-hot event select from the priority encoder
// ---------------------------------------------------------------------------
package exc_flush_ctrl_pkg;

   localparam logic [5:0] ECODE_INT = 6'h00;
   localparam logic [5:0] ECODE_SYS = 6'h0B;
   localparam logic [5:0] ECODE_BRK = 6'h0C;
   localparam logic [5:0] ECODE_INE = 6'h0D;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_FLUSH    = 2'd1,
      ST_REDIRECT = 2'd2
   } state_e;

   // One-hot event select: exactly one bit set when an event is taken.
   localparam int SEL_INT  = 0;
   localparam int SEL_EXC  = 1;
   localparam int SEL_ERTN = 2;

endpackage

// File: rtl/exc_flush_ctrl_prio_enc.sv
// ---------------------------------------------------------------------------
// exc_prio_enc
// Fixed-priority selection among the three commit-time events
// (interrupt > synchronous exception > ERTN) plus the ecode/esubcode mux.
// Ports:
//   int_i, exc_i, ertn_i   qualified event requests
//   ecode_i, esubcode_i    exception code/subcode from WB
//   sel_o                  one-hot winner, bit positions SEL_* from the package
//   ecode_o, esubcode_o    code reported for the winner (interrupt -> ECODE_INT/0,
//                          ERTN or nothing -> 0)
// ---------------------------------------------------------------------------
module exc_prio_enc
   import exc_flush_ctrl_pkg::*;
(
   input  logic       int_i,
   input  logic       exc_i,
   input  logic       ertn_i,
   input  logic [5:0] ecode_i,
   input  logic [8:0] esubcode_i,
   output logic [2:0] sel_o,
   output logic [5:0] ecode_o,
   output logic [8:0] esubcode_o
);

   always_comb begin
      sel_o      = '0;
      ecode_o    = ECODE_INT;
      esubcode_o = '0;
      if (int_i) begin
         sel_o[SEL_INT] = 1'b1;
      end else if (exc_i) begin
         sel_o[SEL_EXC] = 1'b1;
         ecode_o        = ecode_i;
         esubcode_o     = esubcode_i;
      end else if (ertn_i) begin
         sel_o[SEL_ERTN] = 1'b1;
      end
   end

endmodule

// File: rtl/exc_flush_ctrl.sv
// ---------------------------------------------------------------------------
// exc_flush_ctrl
// Pipeline recovery sequencer for commit-time events (interrupt, synchronous
// exception, ERTN). In IDLE it watches WB; on an event it pulses the CSR file
// (ex_commit / ertn_commit) in the same cycle, captures the new fetch target,
// flushes IF/ID/EXE/MEM for FLUSH_CYCLES cycles, then presents the redirect
// to IF and holds it (with the flush) until redirect_ready.
// Ports:
//   clk, resetn                 clock, synchronous active-low reset
//   wb_valid/ex/ecode/esubcode/pc/ertn   WB instruction status
//   has_int                     IE-gated pending interrupt from CSR
//   csr_eentry, csr_era         exception entry / return addresses
//   ex_commit, ex_ecode, ex_esubcode, ex_pc   exception save strobe + payload
//   ertn_commit                 ERTN restore strobe
//   commit_inhibit              WB must not write RF/CSR this cycle
//   flush_bus                   {if,id,exe,mem} flush
//   redirect_valid/pc/ready     redirect handshake toward IF; valid stays high
//                               with a stable pc until a cycle with ready=1
//   dbg_state_o                 current FSM state (state_e encoding)
// ---------------------------------------------------------------------------
module exc_flush_ctrl
   import exc_flush_ctrl_pkg::*;
#(
   parameter int FLUSH_CYCLES = 1,
   parameter int CNT_W        = 4
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        wb_valid,
   input  logic        wb_ex,
   input  logic [5:0]  wb_ecode,
   input  logic [8:0]  wb_esubcode,
   input  logic [31:0] wb_pc,
   input  logic        wb_ertn,
   input  logic        has_int,
   input  logic [31:0] csr_eentry,
   input  logic [31:0] csr_era,
   output logic        ex_commit,
   output logic [5:0]  ex_ecode,
   output logic [8:0]  ex_esubcode,
   output logic [31:0] ex_pc,
   output logic        ertn_commit,
   output logic        commit_inhibit,
   output logic [3:0]  flush_bus,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   input  logic        redirect_ready,
   output logic [1:0]  dbg_state_o
);

   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(FLUSH_CYCLES - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      target_q, target_d;

   logic       evt_qual;
   logic [2:0] sel;
   logic [5:0] enc_ecode;
   logic [8:0] enc_esubcode;
   logic       evt;

   // Events are only looked at in IDLE on a valid WB slot; gating with resetn
   // keeps the CSR strobes quiet while reset is being applied.
   assign evt_qual = (state_q == ST_IDLE) && wb_valid && resetn;

   exc_prio_enc u_prio_enc (
      .int_i      (evt_qual & has_int),
      .exc_i      (evt_qual & wb_ex),
      .ertn_i     (evt_qual & wb_ertn),
      .ecode_i    (wb_ecode),
      .esubcode_i (wb_esubcode),
      .sel_o      (sel),
      .ecode_o    (enc_ecode),
      .esubcode_o (enc_esubcode)
   );

   assign evt         = |sel;
   assign dbg_state_o = state_q;

   // State register
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         target_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         target_q <= target_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      target_d = target_q;
      case (state_q)
         ST_IDLE: begin
            if (evt) begin
               state_d  = ST_FLUSH;
               cnt_d    = CNT_INIT;
               // ERA is sampled now, before the ERTN restore reaches the CSRs.
               target_d = sel[SEL_ERTN] ? csr_era : csr_eentry;
            end
         end
         ST_FLUSH: begin
            if (cnt_q == '0) state_d = ST_REDIRECT;
            else             cnt_d   = cnt_q - 1'b1;
         end
         ST_REDIRECT: begin
            if (redirect_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      ex_commit      = 1'b0;
      ex_ecode       = '0;
      ex_esubcode    = '0;
      ex_pc          = '0;
      ertn_commit    = 1'b0;
      commit_inhibit = 1'b0;
      flush_bus      = 4'b0000;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      case (state_q)
         ST_IDLE: begin
            ex_commit      = sel[SEL_INT] | sel[SEL_EXC];
            ertn_commit    = sel[SEL_ERTN];
            ex_ecode       = enc_ecode;
            ex_esubcode    = enc_esubcode;
            ex_pc          = evt ? wb_pc : 32'h0;
            commit_inhibit = evt;
         end
         ST_FLUSH: begin
            flush_bus      = 4'b1111;
            commit_inhibit = 1'b1;
         end
         ST_REDIRECT: begin
            flush_bus      = 4'b1111;
            commit_inhibit = 1'b1;
            redirect_valid = 1'b1;
            redirect_pc    = target_q;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_exc_flush_ctrl.sv
module tb_exc_flush_ctrl;
   import exc_flush_ctrl_pkg::*;

   // ---------------- clock / reset / stimulus signals ----------------
   logic        clk = 1'b0;
   logic        resetn;
   logic        wb_valid, wb_ex, wb_ertn, has_int, redirect_ready;
   logic [5:0]  wb_ecode;
   logic [8:0]  wb_esubcode;
   logic [31:0] wb_pc, csr_eentry, csr_era;

   always #5 clk = ~clk;

   typedef struct packed {
      logic        exc;
      logic        ertn;
      logic        inh;
      logic [5:0]  ecode;
      logic [8:0]  esub;
      logic [31:0] expc;
      logic [3:0]  flush;
      logic        rv;
      logic [31:0] rpc;
   } out_t;

   // Two instances share the stimulus: default FLUSH_CYCLES=1 and FLUSH_CYCLES=3.
   logic        exc_1, ertn_1, inh_1, rv_1, exc_3, ertn_3, inh_3, rv_3;
   logic [5:0]  ecode_1, ecode_3;
   logic [8:0]  esub_1, esub_3;
   logic [31:0] expc_1, rpc_1, expc_3, rpc_3;
   logic [3:0]  flush_1, flush_3;
   logic [1:0]  dbg_1, dbg_3;
   out_t        o1, o3;

   assign o1 = {exc_1, ertn_1, inh_1, ecode_1, esub_1, expc_1, flush_1, rv_1, rpc_1};
   assign o3 = {exc_3, ertn_3, inh_3, ecode_3, esub_3, expc_3, flush_3, rv_3, rpc_3};

   exc_flush_ctrl u1 (
      .clk(clk), .resetn(resetn), .wb_valid(wb_valid), .wb_ex(wb_ex),
      .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode), .wb_pc(wb_pc),
      .wb_ertn(wb_ertn), .has_int(has_int), .csr_eentry(csr_eentry),
      .csr_era(csr_era), .ex_commit(exc_1), .ex_ecode(ecode_1),
      .ex_esubcode(esub_1), .ex_pc(expc_1), .ertn_commit(ertn_1),
      .commit_inhibit(inh_1), .flush_bus(flush_1), .redirect_valid(rv_1),
      .redirect_pc(rpc_1), .redirect_ready(redirect_ready), .dbg_state_o(dbg_1)
   );

   exc_flush_ctrl #(.FLUSH_CYCLES(3), .CNT_W(4)) u3 (
      .clk(clk), .resetn(resetn), .wb_valid(wb_valid), .wb_ex(wb_ex),
      .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode), .wb_pc(wb_pc),
      .wb_ertn(wb_ertn), .has_int(has_int), .csr_eentry(csr_eentry),
      .csr_era(csr_era), .ex_commit(exc_3), .ex_ecode(ecode_3),
      .ex_esubcode(esub_3), .ex_pc(expc_3), .ertn_commit(ertn_3),
      .commit_inhibit(inh_3), .flush_bus(flush_3), .redirect_valid(rv_3),
      .redirect_pc(rpc_3), .redirect_ready(redirect_ready), .dbg_state_o(dbg_3)
   );

   // ---------------- scoreboard counters ----------------
   int n_cmp = 0;
   int n_err = 0;
   logic chk_en = 1'b0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic check_zero(input string nm, input out_t act);
      n_cmp++;
      if (act !== '0) begin
         n_err++;
         $display("FAIL %s: got %h expected all-zero outputs", nm, act);
      end
   endtask

   // ---------------- reference model ----------------
   // Per instance: busy flag, cycles elapsed since the event (1 = first flush
   // cycle), and the captured fetch target. Flush lasts cycles 1..FC, redirect
   // is offered from cycle FC+1 until a cycle with redirect_ready.
   int          fc_of [2] = '{1, 3};
   logic        m_busy[2];
   int          m_k   [2];
   logic [31:0] m_tgt [2];

   initial begin
      m_busy = '{1'b0, 1'b0};
      m_k    = '{0, 0};
      m_tgt  = '{32'h0, 32'h0};
   end

   always @(negedge clk) begin : model
      out_t  e, obs;
      logic  evt;
      string tag;
      if (chk_en) begin
         for (int u = 0; u < 2; u++) begin
            obs = (u == 0) ? o1 : o3;
            tag = (u == 0) ? "m1" : "m3";
            e   = '0;
            evt = 1'b0;
            if (!m_busy[u]) begin
               if (resetn && wb_valid && (has_int || wb_ex || wb_ertn)) begin
                  evt    = 1'b1;
                  e.inh  = 1'b1;
                  e.expc = wb_pc;
                  if (has_int) begin
                     e.exc = 1'b1; e.ecode = ECODE_INT; e.esub = 9'h0;
                  end else if (wb_ex) begin
                     e.exc = 1'b1; e.ecode = wb_ecode; e.esub = wb_esubcode;
                  end else begin
                     e.ertn = 1'b1;
                  end
               end
            end else begin
               e.flush = 4'hF;
               e.inh   = 1'b1;
               if (m_k[u] > fc_of[u]) begin
                  e.rv  = 1'b1;
                  e.rpc = m_tgt[u];
               end
            end
            check({tag, "_ex_commit"},   32'(obs.exc),   32'(e.exc));
            check({tag, "_ertn_commit"}, 32'(obs.ertn),  32'(e.ertn));
            check({tag, "_inhibit"},     32'(obs.inh),   32'(e.inh));
            check({tag, "_flush"},       32'(obs.flush), 32'(e.flush));
            check({tag, "_rvalid"},      32'(obs.rv),    32'(e.rv));
            if (e.exc) begin
               check({tag, "_ecode"}, 32'(obs.ecode), 32'(e.ecode));
               check({tag, "_esub"},  32'(obs.esub),  32'(e.esub));
            end
            if (evt)  check({tag, "_ex_pc"}, obs.expc, e.expc);
            if (e.rv) check({tag, "_rpc"},   obs.rpc,  e.rpc);
            // advance to the state after the coming edge
            if (!resetn) begin
               m_busy[u] = 1'b0;
            end else if (!m_busy[u]) begin
               if (evt) begin
                  m_busy[u] = 1'b1;
                  m_k[u]    = 1;
                  m_tgt[u]  = e.ertn ? csr_era : csr_eentry;
               end
            end else if (m_k[u] <= fc_of[u]) begin
               m_k[u] = m_k[u] + 1;
            end else if (redirect_ready) begin
               m_busy[u] = 1'b0;
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle();
      wb_valid = 1'b0; wb_ex = 1'b0; wb_ertn = 1'b0; has_int = 1'b0;
      wb_ecode = 6'h0; wb_esubcode = 9'h0; wb_pc = 32'h0;
      redirect_ready = 1'b1;
   endtask

   task automatic drain(input int n);
      set_idle();
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         tick();
      end
   endtask

   // ---------------- directed vector table (checked on u1, FLUSH_CYCLES=1) ----------------
   typedef struct {
      string       name;
      logic        valid, ex, ertn, intr, ready;
      logic [5:0]  ecode;
      logic [8:0]  esub;
      logic [31:0] pc, eentry, era;
      logic        e_exc, e_ertn, e_inh, e_rv;
      logic [5:0]  e_ecode;
      logic [31:0] e_expc;
      logic [3:0]  e_flush;
      logic [31:0] e_rpc;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input string name,
                               input logic valid, ex, ertn, intr, ready,
                               input logic [5:0] ecode, input logic [8:0] esub,
                               input logic [31:0] pc, eentry, era,
                               input logic e_exc, e_ertn, e_inh, e_rv,
                               input logic [5:0] e_ecode, input logic [31:0] e_expc,
                               input logic [3:0] e_flush, input logic [31:0] e_rpc);
      vec_t v;
      v.name = name; v.valid = valid; v.ex = ex; v.ertn = ertn; v.intr = intr;
      v.ready = ready; v.ecode = ecode; v.esub = esub; v.pc = pc;
      v.eentry = eentry; v.era = era; v.e_exc = e_exc; v.e_ertn = e_ertn;
      v.e_inh = e_inh; v.e_rv = e_rv; v.e_ecode = e_ecode; v.e_expc = e_expc;
      v.e_flush = e_flush; v.e_rpc = e_rpc;
      return v;
   endfunction

   localparam logic [31:0] EENTRY = 32'h1C008000;

   initial begin
      //            name          vl ex er in rd ecode esub  pc            eentry  era           eX eR iN rV eEc   e_expc        fl    e_rpc
      tbl.push_back(mk("sys_T",   1, 1, 0, 0, 1, 6'h0B, 9'h0, 32'h1C000100, EENTRY, 32'h0,        1, 0, 1, 0, 6'h0B, 32'h1C000100, 4'h0, 32'h0));
      tbl.push_back(mk("sys_T1",  0, 0, 0, 0, 1, 6'h00, 9'h0, 32'h0,        EENTRY, 32'h0,        0, 0, 1, 0, 6'h00, 32'h0,        4'hF, 32'h0));
      tbl.push_back(mk("sys_T2",  0, 0, 0, 0, 1, 6'h00, 9'h0, 32'h0,        EENTRY, 32'h0,        0, 0, 1, 1, 6'h00, 32'h0,        4'hF, EENTRY));
      tbl.push_back(mk("sys_T3",  0, 0, 0, 0, 1, 6'h00, 9'h0, 32'h0,        EENTRY, 32'h0,        0, 0, 0, 0, 6'h00, 32'h0,        4'h0, 32'h0));
      tbl.push_back(mk("ertn_T",  1, 0, 1, 0, 1, 6'h00, 9'h0, 32'h1C000200, EENTRY, 32'h1C000104, 0, 1, 1, 0, 6'h00, 32'h1C000200, 4'h0, 32'h0));
      tbl.push_back(mk("ertn_T1", 0, 0, 0, 0, 1, 6'h00, 9'h0, 32'h0,        EENTRY, 32'hDEAD0000, 0, 0, 1, 0, 6'h00, 32'h0,        4'hF, 32'h0));
      tbl.push_back(mk("ertn_T2", 0, 0, 0, 0, 1, 6'h00, 9'h0, 32'h0,        EENTRY, 32'hDEAD0000, 0, 0, 1, 1, 6'h00, 32'h0,        4'hF, 32'h1C000104));
      tbl.push_back(mk("ertn_T3", 0, 0, 0, 0, 1, 6'h00, 9'h0, 32'h0,        EENTRY, 32'h0,        0, 0, 0, 0, 6'h00, 32'h0,        4'h0, 32'h0));
      tbl.push_back(mk("prio_T",  1, 1, 0, 1, 1, 6'h0B, 9'h5, 32'h1C000300, EENTRY, 32'h0,        1, 0, 1, 0, 6'h00, 32'h1C000300, 4'h0, 32'h0));
      tbl.push_back(mk("prio_T1", 1, 1, 0, 1, 1, 6'h0B, 9'h5, 32'h1C000304, EENTRY, 32'h0,        0, 0, 1, 0, 6'h00, 32'h0,        4'hF, 32'h0));
      tbl.push_back(mk("prio_T2", 1, 1, 0, 1, 1, 6'h0B, 9'h5, 32'h1C000308, EENTRY, 32'h0,        0, 0, 1, 1, 6'h00, 32'h0,        4'hF, EENTRY));
      tbl.push_back(mk("int_nv",  0, 0, 0, 1, 1, 6'h00, 9'h0, 32'h1C000400, EENTRY, 32'h0,        0, 0, 0, 0, 6'h00, 32'h0,        4'h0, 32'h0));
      tbl.push_back(mk("int_v",   1, 0, 0, 1, 1, 6'h00, 9'h0, 32'h1C000404, EENTRY, 32'h0,        1, 0, 1, 0, 6'h00, 32'h1C000404, 4'h0, 32'h0));
      tbl.push_back(mk("int_T1",  0, 0, 0, 0, 1, 6'h00, 9'h0, 32'h0,        EENTRY, 32'h0,        0, 0, 1, 0, 6'h00, 32'h0,        4'hF, 32'h0));
      tbl.push_back(mk("int_T2",  0, 0, 0, 0, 1, 6'h00, 9'h0, 32'h0,        EENTRY, 32'h0,        0, 0, 1, 1, 6'h00, 32'h0,        4'hF, EENTRY));
      tbl.push_back(mk("exer_T",  1, 1, 1, 0, 1, 6'h0D, 9'h3, 32'h1C000500, EENTRY, 32'h1C000900, 1, 0, 1, 0, 6'h0D, 32'h1C000500, 4'h0, 32'h0));
      tbl.push_back(mk("exer_T1", 0, 0, 0, 0, 1, 6'h00, 9'h0, 32'h0,        EENTRY, 32'h0,        0, 0, 1, 0, 6'h00, 32'h0,        4'hF, 32'h0));
      tbl.push_back(mk("exer_T2", 0, 0, 0, 0, 1, 6'h00, 9'h0, 32'h0,        EENTRY, 32'h0,        0, 0, 1, 1, 6'h00, 32'h0,        4'hF, EENTRY));
      tbl.push_back(mk("exer_T3", 0, 0, 0, 0, 1, 6'h00, 9'h0, 32'h0,        EENTRY, 32'h0,        0, 0, 0, 0, 6'h00, 32'h0,        4'h0, 32'h0));
   end

   // ---------------- main test sequence ----------------
   initial begin
      resetn = 1'b0;
      csr_eentry = 32'h0; csr_era = 32'h0;
      set_idle();
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      check_zero("reset_u1", o1);
      check_zero("reset_u3", o3);
      check("reset_state", 32'(dbg_1), 32'(ST_IDLE));
      chk_en = 1'b1;
      tick();
      resetn = 1'b1;

      // table-driven directed vectors
      for (int i = 0; i < tbl.size(); i++) begin
         wb_valid = tbl[i].valid; wb_ex = tbl[i].ex; wb_ertn = tbl[i].ertn;
         has_int = tbl[i].intr; redirect_ready = tbl[i].ready;
         wb_ecode = tbl[i].ecode; wb_esubcode = tbl[i].esub; wb_pc = tbl[i].pc;
         csr_eentry = tbl[i].eentry; csr_era = tbl[i].era;
         @(negedge clk);
         check({tbl[i].name, "_ex_commit"},   32'(exc_1),   32'(tbl[i].e_exc));
         check({tbl[i].name, "_ertn_commit"}, 32'(ertn_1),  32'(tbl[i].e_ertn));
         check({tbl[i].name, "_inhibit"},     32'(inh_1),   32'(tbl[i].e_inh));
         check({tbl[i].name, "_flush"},       32'(flush_1), 32'(tbl[i].e_flush));
         check({tbl[i].name, "_rvalid"},      32'(rv_1),    32'(tbl[i].e_rv));
         if (tbl[i].e_exc) check({tbl[i].name, "_ecode"}, 32'(ecode_1), 32'(tbl[i].e_ecode));
         if (tbl[i].e_exc || tbl[i].e_ertn) check({tbl[i].name, "_ex_pc"}, expc_1, tbl[i].e_expc);
         if (tbl[i].e_rv) check({tbl[i].name, "_rpc"}, rpc_1, tbl[i].e_rpc);
         tick();
      end

      // backpressure: 5 cycles of ready=0 in redirect, a second exception ignored
      drain(8);
      wb_valid = 1'b1; wb_ex = 1'b1; wb_ecode = ECODE_SYS; wb_pc = 32'h1C000600;
      csr_eentry = 32'h1C008800; redirect_ready = 1'b0;
      @(negedge clk);
      check("bp_commit", 32'(exc_1), 1);
      tick();
      set_idle(); redirect_ready = 1'b0;
      @(negedge clk);
      check("bp_flush", 32'(flush_1), 32'hF);
      tick();
      for (int i = 0; i < 5; i++) begin
         wb_valid = (i == 2); wb_ex = (i == 2);
         csr_eentry = (i == 2) ? 32'h0BAD0000 : 32'h1C008800;
         @(negedge clk);
         check("bp_wait_rvalid", 32'(rv_1), 1);
         check("bp_wait_rpc", rpc_1, 32'h1C008800);
         check("bp_wait_nocommit", 32'(exc_1), 0);
         check("bp_wait_state", 32'(dbg_1), 32'(ST_REDIRECT));
         tick();
      end
      set_idle();
      @(negedge clk);
      check("bp_accept_rvalid", 32'(rv_1), 1);
      check("bp_accept_rpc", rpc_1, 32'h1C008800);
      tick();
      @(negedge clk);
      check("bp_after_rvalid", 32'(rv_1), 0);
      check("bp_after_flush", 32'(flush_1), 0);
      tick();

      // FLUSH_CYCLES=3 instance: three flush cycles, then redirect
      drain(8);
      wb_valid = 1'b1; wb_ex = 1'b1; wb_ecode = ECODE_BRK; wb_pc = 32'h1C000700;
      csr_eentry = 32'h1C00A000;
      @(negedge clk);
      check("fc3_commit", 32'(exc_3), 1);
      check("fc3_inhibit_T", 32'(inh_3), 1);
      tick();
      set_idle();
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk);
         check("fc3_flush", 32'(flush_3), 32'hF);
         check("fc3_inhibit", 32'(inh_3), 1);
         check("fc3_no_rvalid", 32'(rv_3), 0);
         tick();
      end
      @(negedge clk);
      check("fc3_rvalid", 32'(rv_3), 1);
      check("fc3_rpc", rpc_3, 32'h1C00A000);
      check("fc3_inhibit_r", 32'(inh_3), 1);
      tick();
      @(negedge clk);
      check("fc3_idle", 32'(rv_3), 0);
      tick();

      // reset while u1 sits in REDIRECT
      drain(8);
      wb_valid = 1'b1; has_int = 1'b1; wb_pc = 32'h1C000800;
      csr_eentry = 32'h1C00B000; redirect_ready = 1'b0;
      @(negedge clk);
      tick();
      set_idle(); redirect_ready = 1'b0;
      @(negedge clk);
      tick();
      resetn = 1'b0;
      @(negedge clk);
      check("rst_pre_rvalid", 32'(rv_1), 1);
      tick();
      resetn = 1'b1;
      @(negedge clk);
      check_zero("rst_u1", o1);
      check_zero("rst_u3", o3);
      tick();
      wb_valid = 1'b1; wb_ex = 1'b1; wb_ecode = ECODE_INE; wb_pc = 32'h1C000900;
      csr_eentry = 32'h1C00C000; redirect_ready = 1'b1;
      @(negedge clk);
      check("rst_new_commit", 32'(exc_1), 1);
      check("rst_new_ecode", 32'(ecode_1), 32'(ECODE_INE));
      tick();
      set_idle();
      @(negedge clk);
      tick();
      @(negedge clk);
      check("rst_new_rpc", rpc_1, 32'h1C00C000);
      tick();

      // randomized traffic, both instances checked by the model
      for (int i = 0; i < 3000; i++) begin
         resetn         = ($urandom_range(0, 199) != 0);
         wb_valid       = ($urandom_range(0, 2) != 0);
         wb_ex          = ($urandom_range(0, 3) == 0);
         wb_ertn        = ($urandom_range(0, 4) == 0);
         has_int        = ($urandom_range(0, 6) == 0);
         wb_ecode       = 6'($urandom);
         wb_esubcode    = 9'($urandom);
         wb_pc          = $urandom;
         csr_eentry     = $urandom;
         csr_era        = $urandom;
         redirect_ready = ($urandom_range(0, 2) != 0);
         @(negedge clk);
         tick();
      end
      resetn = 1'b1;
      set_idle();
      @(negedge clk);
      chk_en = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
